// File: rtl/rv_mc_control_unit_pkg.sv
// Shared constants for the multicycle RV32I controller: opcodes, funct codes, FSM states and mux codes.
package rv_mc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM,
        S_WB_ALU, S_WB_MEM, S_WB_U, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
        ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_SRA = 4'd9
    } alu_ctl_t;

    typedef enum logic [2:0] {
        ALU_CLS_ADD, ALU_CLS_MEM, ALU_CLS_JALR, ALU_CLS_BRANCH, ALU_CLS_R, ALU_CLS_I
    } alu_cls_t;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

    localparam logic [1:0] RES_ALUOUT  = 2'd0;
    localparam logic [1:0] RES_MEMDATA = 2'd1;
    localparam logic [1:0] RES_ALU     = 2'd2;

    localparam logic [1:0] RD_RESULT = 2'd0;
    localparam logic [1:0] RD_PC4    = 2'd1;
    localparam logic [1:0] RD_UIMM   = 2'd2;
    localparam logic [1:0] RD_CMP    = 2'd3;

    function automatic logic opcode_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_mc_control_unit_if.sv
// Memory handshake bundle between the controller (master) and the unified instr/data memory (slave).
interface rv_mc_control_unit_if;
    logic mem_req;
    logic mem_we;
    logic adr_src;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output adr_src, input mem_ready);
    modport slave  (input mem_req, input mem_we, input adr_src, output mem_ready);
endinterface

// File: rtl/rv_mc_control_unit_alu_decode.sv
// Combinational ALU decoder: operation class + funct3/funct7 -> alu_ctl, plus illegal-funct detection.
module rv_alu_decode
    import rv_mc_pkg::*;
(
    input  alu_cls_t   i_cls,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output alu_ctl_t   o_alu_ctl,
    output logic       o_illegal_funct
);

    logic w_f7_base;
    logic w_f7_alt;
    logic w_is_r;

    assign w_f7_base = (i_funct7 == F7_BASE);
    assign w_f7_alt  = (i_funct7 == F7_ALT);
    assign w_is_r    = (i_cls == ALU_CLS_R);

    always_comb begin
        o_alu_ctl       = ALU_ADD;
        o_illegal_funct = 1'b0;
        case (i_cls)
            ALU_CLS_MEM:  o_illegal_funct = (i_funct3 != F3_WORD);
            ALU_CLS_JALR: o_illegal_funct = (i_funct3 != 3'b000);
            ALU_CLS_BRANCH: begin
                o_alu_ctl       = ALU_SUB;
                o_illegal_funct = (i_funct3 == 3'b010) || (i_funct3 == 3'b011);
            end
            ALU_CLS_R, ALU_CLS_I: begin
                // I-type ignores funct7 (it is immediate) except on shifts, where it encodes SRA/zero.
                case (i_funct3)
                    F3_ADD: begin
                        o_alu_ctl       = (w_is_r && w_f7_alt) ? ALU_SUB : ALU_ADD;
                        o_illegal_funct = w_is_r && !(w_f7_base || w_f7_alt);
                    end
                    F3_SLL: begin
                        o_alu_ctl       = ALU_SLL;
                        o_illegal_funct = !w_f7_base;
                    end
                    F3_SLT: begin
                        o_alu_ctl       = ALU_SLT;
                        o_illegal_funct = w_is_r && !w_f7_base;
                    end
                    F3_SLTU: begin
                        o_alu_ctl       = ALU_SLTU;
                        o_illegal_funct = w_is_r && !w_f7_base;
                    end
                    F3_XOR: begin
                        o_alu_ctl       = ALU_XOR;
                        o_illegal_funct = w_is_r && !w_f7_base;
                    end
                    F3_SR: begin
                        o_alu_ctl       = w_f7_alt ? ALU_SRA : ALU_SRL;
                        o_illegal_funct = !(w_f7_base || w_f7_alt);
                    end
                    F3_OR: begin
                        o_alu_ctl       = ALU_OR;
                        o_illegal_funct = w_is_r && !w_f7_base;
                    end
                    default: begin
                        o_alu_ctl       = ALU_AND;
                        o_illegal_funct = w_is_r && !w_f7_base;
                    end
                endcase
            end
            default: o_alu_ctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv_mc_control_unit.sv
// Multicycle RV32I control FSM with ready/valid memory handshake, timeout fault and instret counter.
// Build option: define RV_MC_ILLEGAL_TRAP_EN to halt on illegal instructions and expose o_illegal.
module rv_mc_control_unit
    import rv_mc_pkg::*;
#(
    parameter int ALUCTL_W    = 4,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           i_opcode,
    input  logic [2:0]           i_funct3,
    input  logic [6:0]           i_funct7,
    input  logic                 i_zero,
    input  logic                 i_neg,
    input  logic                 i_ltu,
    rv_mc_control_unit_if.master mem,
    output logic                 o_ir_write,
    output logic                 o_pc_en,
    output logic                 o_reg_write,
    output logic [2:0]           o_imm_src,
    output logic [1:0]           o_alu_src_a,
    output logic [1:0]           o_alu_src_b,
    output logic [ALUCTL_W-1:0]  o_alu_ctl,
    output logic [1:0]           o_result_src,
    output logic [1:0]           o_reg_data_sel,
    output logic                 o_retire,
    output logic [CNT_W-1:0]     o_instret,
`ifdef RV_MC_ILLEGAL_TRAP_EN
    output logic                 o_fault,
    output logic                 o_illegal
`else
    output logic                 o_fault
`endif
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_instret;
    logic              r_fault;
    logic              w_set_fault;
    logic              w_timeout;
    logic              w_mem_req;
    logic              w_mem_we;
    logic              w_adr_src;
    logic              w_is_slt;
    alu_cls_t          w_cls;
    alu_ctl_t          w_alu_ctl;
    logic              w_illegal_funct;
`ifdef RV_MC_ILLEGAL_TRAP_EN
    logic              r_illegal;
    logic              w_set_illegal;
`endif

    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n,
                                          input logic u);
        case (f3)
            F3_BEQ:  return z;
            F3_BNE:  return !z;
            F3_BLT:  return n;
            F3_BGE:  return !n;
            F3_BLTU: return u;
            F3_BGEU: return !u;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        w_cls = ALU_CLS_ADD;
        if (r_state == S_EXEC) begin
            case (i_opcode)
                OP_R:              w_cls = ALU_CLS_R;
                OP_I:              w_cls = ALU_CLS_I;
                OP_LOAD, OP_STORE: w_cls = ALU_CLS_MEM;
                OP_BRANCH:         w_cls = ALU_CLS_BRANCH;
                OP_JALR:           w_cls = ALU_CLS_JALR;
                default:           w_cls = ALU_CLS_ADD;
            endcase
        end
    end

    rv_alu_decode u_alu_decode (
        .i_cls           (w_cls),
        .i_funct3        (i_funct3),
        .i_funct7        (i_funct7),
        .o_alu_ctl       (w_alu_ctl),
        .o_illegal_funct (w_illegal_funct)
    );

    assign w_timeout = (MEM_TIMEOUT > 0) && !mem.mem_ready && (r_wait_cnt == WAIT_LAST);
    assign w_is_slt  = ((i_opcode == OP_R) || (i_opcode == OP_I)) &&
                       ((i_funct3 == F3_SLT) || (i_funct3 == F3_SLTU));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_adr_src      = 1'b0;
        o_ir_write     = 1'b0;
        o_pc_en        = 1'b0;
        o_reg_write    = 1'b0;
        o_imm_src      = IMM_I;
        o_alu_src_a    = SRCA_PC;
        o_alu_src_b    = SRCB_RS2;
        o_alu_ctl      = ALUCTL_W'(ALU_ADD);
        o_result_src   = RES_ALUOUT;
        o_reg_data_sel = RD_RESULT;
        o_retire       = 1'b0;
        w_set_fault    = 1'b0;
`ifdef RV_MC_ILLEGAL_TRAP_EN
        w_set_illegal  = 1'b0;
`endif
        case (r_state)
            S_IDLE: w_state_nxt = S_FETCH;
            S_FETCH: begin
                w_mem_req    = 1'b1;
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALU;
                if (mem.mem_ready) begin
                    o_ir_write  = 1'b1;
                    o_pc_en     = 1'b1;
                    w_state_nxt = S_DECODE;
                end else if (w_timeout) begin
                    w_set_fault = 1'b1;
                    w_state_nxt = S_HALT;
                end
            end
            S_DECODE: begin
                // Branch/jump target OldPC+imm is parked in ALUOut for EXEC.
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_IMM;
                o_imm_src   = (i_opcode == OP_BRANCH) ? IMM_B :
                              (i_opcode == OP_JAL)    ? IMM_J : IMM_I;
                if (!opcode_legal(i_opcode)) begin
`ifdef RV_MC_ILLEGAL_TRAP_EN
                    w_set_illegal = 1'b1;
                    w_state_nxt   = S_HALT;
`else
                    o_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
`endif
                end else if (i_opcode == OP_LUI) begin
                    w_state_nxt = S_WB_U;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                o_alu_ctl = ALUCTL_W'(w_alu_ctl);
                if (w_illegal_funct) begin
`ifdef RV_MC_ILLEGAL_TRAP_EN
                    w_set_illegal = 1'b1;
                    w_state_nxt   = S_HALT;
`else
                    o_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
`endif
                end else begin
                    case (i_opcode)
                        OP_R: begin
                            o_alu_src_a = SRCA_RS1;
                            w_state_nxt = S_WB_ALU;
                        end
                        OP_I: begin
                            o_alu_src_a = SRCA_RS1;
                            o_alu_src_b = SRCB_IMM;
                            w_state_nxt = S_WB_ALU;
                        end
                        OP_LOAD, OP_STORE: begin
                            o_alu_src_a = SRCA_RS1;
                            o_alu_src_b = SRCB_IMM;
                            o_imm_src   = (i_opcode == OP_STORE) ? IMM_S : IMM_I;
                            w_state_nxt = S_MEM;
                        end
                        OP_BRANCH: begin
                            o_alu_src_a = SRCA_RS1;
                            o_imm_src   = IMM_B;
                            o_pc_en     = branch_taken(i_funct3, i_zero, i_neg, i_ltu);
                            o_retire    = 1'b1;
                            w_state_nxt = S_FETCH;
                        end
                        OP_JAL: begin
                            o_imm_src      = IMM_J;
                            o_pc_en        = 1'b1;
                            o_reg_write    = 1'b1;
                            o_reg_data_sel = RD_PC4;
                            o_retire       = 1'b1;
                            w_state_nxt    = S_FETCH;
                        end
                        OP_JALR: begin
                            o_alu_src_a    = SRCA_RS1;
                            o_alu_src_b    = SRCB_IMM;
                            o_result_src   = RES_ALU;
                            o_pc_en        = 1'b1;
                            o_reg_write    = 1'b1;
                            o_reg_data_sel = RD_PC4;
                            o_retire       = 1'b1;
                            w_state_nxt    = S_FETCH;
                        end
                        default: w_state_nxt = S_FETCH;
                    endcase
                end
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                w_mem_we  = (i_opcode == OP_STORE);
                if (mem.mem_ready) begin
                    if (i_opcode == OP_STORE) begin
                        o_retire    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_WB_MEM;
                    end
                end else if (w_timeout) begin
                    w_set_fault = 1'b1;
                    w_state_nxt = S_HALT;
                end
            end
            S_WB_ALU: begin
                o_reg_write    = 1'b1;
                o_reg_data_sel = w_is_slt ? RD_CMP : RD_RESULT;
                o_retire       = 1'b1;
                w_state_nxt    = S_FETCH;
            end
            S_WB_MEM: begin
                o_reg_write  = 1'b1;
                o_result_src = RES_MEMDATA;
                o_retire     = 1'b1;
                w_state_nxt  = S_FETCH;
            end
            S_WB_U: begin
                o_reg_write    = 1'b1;
                o_imm_src      = IMM_U;
                o_reg_data_sel = RD_UIMM;
                o_retire       = 1'b1;
                w_state_nxt    = S_FETCH;
            end
            default: w_state_nxt = S_HALT;
        endcase
    end

    // Wait counter restarts on every entry into FETCH/MEM and only runs while stalled there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_instret  <= '0;
            r_fault    <= 1'b0;
        end else begin
            if (w_state_nxt != r_state)
                r_wait_cnt <= '0;
            else if ((r_state == S_FETCH) || (r_state == S_MEM))
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            if (o_retire)
                r_instret <= r_instret + CNT_W'(1);
            if (w_set_fault)
                r_fault <= 1'b1;
        end
    end

`ifdef RV_MC_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                r_illegal <= 1'b0;
        else if (w_set_illegal) r_illegal <= 1'b1;
    end

    assign o_illegal = r_illegal;
`endif

    assign mem.mem_req = w_mem_req;
    assign mem.mem_we  = w_mem_we;
    assign mem.adr_src = w_adr_src;
    assign o_instret   = r_instret;
    assign o_fault     = r_fault;

endmodule

// File: tb/tb_rv_mc_control_unit.sv
// Directed bench for rv_mc_control_unit (MEM_TIMEOUT=5); follows RV_MC_ILLEGAL_TRAP_EN if defined.
module tb_rv_mc_control_unit;
    import rv_mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        zero, neg, ltu;
    logic        ir_write, pc_en, reg_write, retire, fault;
    logic [2:0]  imm_src;
    logic [1:0]  alu_src_a, alu_src_b, result_src, reg_data_sel;
    logic [3:0]  alu_ctl;
    logic [31:0] instret;
`ifdef RV_MC_ILLEGAL_TRAP_EN
    logic        illegal;
`endif
    int n_checks = 0;
    int n_errors = 0;

    rv_mc_control_unit_if mem_if ();

    rv_mc_control_unit #(.ALUCTL_W(4), .CNT_W(32), .MEM_TIMEOUT(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_opcode       (opcode),
        .i_funct3       (funct3),
        .i_funct7       (funct7),
        .i_zero         (zero),
        .i_neg          (neg),
        .i_ltu          (ltu),
        .mem            (mem_if),
        .o_ir_write     (ir_write),
        .o_pc_en        (pc_en),
        .o_reg_write    (reg_write),
        .o_imm_src      (imm_src),
        .o_alu_src_a    (alu_src_a),
        .o_alu_src_b    (alu_src_b),
        .o_alu_ctl      (alu_ctl),
        .o_result_src   (result_src),
        .o_reg_data_sel (reg_data_sel),
        .o_retire       (retire),
        .o_instret      (instret),
`ifdef RV_MC_ILLEGAL_TRAP_EN
        .o_fault        (fault),
        .o_illegal      (illegal)
`else
        .o_fault        (fault)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; zero = 1'b0; neg = 1'b0; ltu = 1'b0;
        set_ir(7'd0, 3'd0, 7'd0);
        mem_if.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_if.mem_req), 0);
        check("rst_instret", instret, 0);
        check("rst_fault", 32'(fault), 0);

        // ADD x3,x1,x2 with zero-wait memory
        mem_if.mem_ready = 1'b1;
        set_ir(OP_R, F3_ADD, F7_BASE);
        rst = 1'b0;
        #1;
        check("idle_mem_req", 32'(mem_if.mem_req), 0);
        tick();
        check("add_c1_ir_write", 32'(ir_write), 1);
        check("add_c1_pc_en", 32'(pc_en), 1);
        check("add_c1_mem_req", 32'(mem_if.mem_req), 1);
        check("add_c1_adr_src", 32'(mem_if.adr_src), 0);
        check("add_c1_src_b", 32'(alu_src_b), 2);
        tick();
        check("add_c2_ir_write", 32'(ir_write), 0);
        check("add_c2_mem_req", 32'(mem_if.mem_req), 0);
        check("add_c2_src_a", 32'(alu_src_a), 1);
        tick();
        check("add_c3_alu_ctl", 32'(alu_ctl), 0);
        check("add_c3_src_a", 32'(alu_src_a), 2);
        check("add_c3_reg_write", 32'(reg_write), 0);
        tick();
        check("add_c4_reg_write", 32'(reg_write), 1);
        check("add_c4_retire", 32'(retire), 1);
        check("add_c4_rd_sel", 32'(reg_data_sel), 0);
        tick();
        check("add_instret", instret, 1);
        check("add_next_fetch", 32'(mem_if.mem_req), 1);

        // SLTU -> cmp bit written back
        set_ir(OP_R, F3_SLTU, F7_BASE);
        tick(); tick();
        check("sltu_alu_ctl", 32'(alu_ctl), 6);
        tick();
        check("sltu_rd_sel", 32'(reg_data_sel), 3);
        tick();

        // SRAI
        set_ir(OP_I, F3_SR, F7_ALT);
        tick(); tick();
        check("srai_alu_ctl", 32'(alu_ctl), 9);
        check("srai_src_b", 32'(alu_src_b), 1);
        tick();
        check("srai_rd_sel", 32'(reg_data_sel), 0);
        tick();
        check("srai_instret", instret, 3);

        // LW with 3 wait states in MEM
        set_ir(OP_LOAD, F3_WORD, F7_BASE);
        tick(); tick();
        check("lw_exec_src_b", 32'(alu_src_b), 1);
        check("lw_exec_imm", 32'(imm_src), 0);
        mem_if.mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("lw_wait_mem_req", 32'(mem_if.mem_req), 1);
            check("lw_wait_adr_src", 32'(mem_if.adr_src), 1);
            check("lw_wait_retire", 32'(retire), 0);
            tick();
        end
        mem_if.mem_ready = 1'b1;
        #1;
        check("lw_c7_mem_req", 32'(mem_if.mem_req), 1);
        check("lw_c7_mem_we", 32'(mem_if.mem_we), 0);
        tick();
        check("lw_c8_retire", 32'(retire), 1);
        check("lw_c8_result_src", 32'(result_src), 1);
        check("lw_c8_reg_write", 32'(reg_write), 1);
        tick();
        check("lw_instret", instret, 4);

        // SW
        set_ir(OP_STORE, F3_WORD, F7_BASE);
        tick(); tick();
        check("sw_exec_imm", 32'(imm_src), 1);
        tick();
        check("sw_mem_we", 32'(mem_if.mem_we), 1);
        check("sw_retire", 32'(retire), 1);
        check("sw_reg_write", 32'(reg_write), 0);
        tick();
        check("sw_instret", instret, 5);

        // BLTU taken, BGEU not taken (ltu=1)
        ltu = 1'b1;
        set_ir(OP_BRANCH, F3_BLTU, F7_BASE);
        tick();
        check("bltu_dec_imm", 32'(imm_src), 2);
        tick();
        check("bltu_pc_en", 32'(pc_en), 1);
        check("bltu_alu_ctl", 32'(alu_ctl), 1);
        check("bltu_retire", 32'(retire), 1);
        tick();
        set_ir(OP_BRANCH, F3_BGEU, F7_BASE);
        tick(); tick();
        check("bgeu_pc_en", 32'(pc_en), 0);
        check("bgeu_retire", 32'(retire), 1);
        tick();
        check("br_instret", instret, 7);
        ltu = 1'b0;

        // LUI
        set_ir(OP_LUI, 3'd0, 7'd0);
        tick();
        check("lui_dec_reg_write", 32'(reg_write), 0);
        tick();
        check("lui_reg_write", 32'(reg_write), 1);
        check("lui_rd_sel", 32'(reg_data_sel), 2);
        check("lui_imm", 32'(imm_src), 4);
        tick();
        check("lui_instret", instret, 8);

        // JAL
        set_ir(OP_JAL, 3'd0, 7'd0);
        tick();
        check("jal_dec_imm", 32'(imm_src), 3);
        tick();
        check("jal_pc_en", 32'(pc_en), 1);
        check("jal_reg_write", 32'(reg_write), 1);
        check("jal_rd_sel", 32'(reg_data_sel), 1);
        tick();
        check("jal_instret", instret, 9);

        // Illegal funct7 on an R-type
        set_ir(OP_R, F3_ADD, 7'b0000001);
        tick(); tick();
`ifdef RV_MC_ILLEGAL_TRAP_EN
        check("ilf_retire", 32'(retire), 0);
        tick();
        check("ilf_illegal", 32'(illegal), 1);
        check("ilf_halt_mem_req", 32'(mem_if.mem_req), 0);
        rst = 1'b1;
        #1;
        check("ilf_rst_clears", 32'(illegal), 0);
        tick();
        rst = 1'b0;
        tick();
`else
        check("ilf_retire", 32'(retire), 1);
        check("ilf_reg_write", 32'(reg_write), 0);
        tick();
        check("ilf_instret", instret, 10);
`endif

        // Illegal opcode 7'b1111111
        set_ir(7'b1111111, 3'd0, 7'd0);
        tick();
`ifdef RV_MC_ILLEGAL_TRAP_EN
        check("ilo_retire", 32'(retire), 0);
        tick();
        check("ilo_illegal", 32'(illegal), 1);
        check("ilo_halt_mem_req", 32'(mem_if.mem_req), 0);
        tick();
        check("ilo_illegal_sticky", 32'(illegal), 1);
        check("ilo_halt_ir_write", 32'(ir_write), 0);
`else
        check("ilo_retire", 32'(retire), 1);
        check("ilo_reg_write", 32'(reg_write), 0);
        tick();
        check("ilo_instret", instret, 11);
        check("ilo_next_fetch", 32'(mem_if.mem_req), 1);
`endif

        // Reset asserted mid-MEM
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        set_ir(OP_LOAD, F3_WORD, F7_BASE);
        tick(); tick();
        mem_if.mem_ready = 1'b0;
        tick();
        check("rmem_mem_req", 32'(mem_if.mem_req), 1);
        tick();
        rst = 1'b1;
        #1;
        check("rmem_rst_mem_req", 32'(mem_if.mem_req), 0);
        check("rmem_rst_adr_src", 32'(mem_if.adr_src), 0);
        check("rmem_rst_instret", instret, 0);
        tick();
        rst = 1'b0;
        #1;
        check("rmem_idle_mem_req", 32'(mem_if.mem_req), 0);
        tick();
        check("rmem_fetch_mem_req", 32'(mem_if.mem_req), 1);
        check("rmem_fetch_adr_src", 32'(mem_if.adr_src), 0);

        // Timeout: mem_ready stuck 0 in FETCH
        for (int i = 0; i < 5; i++) begin
            check("to_wait_fault", 32'(fault), 0);
            check("to_wait_mem_req", 32'(mem_if.mem_req), 1);
            tick();
        end
        check("to_fault", 32'(fault), 1);
        check("to_halt_mem_req", 32'(mem_if.mem_req), 0);
        mem_if.mem_ready = 1'b1;
        tick();
        check("to_fault_sticky", 32'(fault), 1);
        check("to_halt_held", 32'(mem_if.mem_req), 0);
        check("to_halt_ir_write", 32'(ir_write), 0);
        rst = 1'b1;
        #1;
        check("to_rst_fault", 32'(fault), 0);
        tick();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
